// File: rtl/mpf_svc_vtp_l1_miss_issue_if.sv
// L1 miss / L2 lookup / L1 fill signal bundle of the VTP L1 miss issuer.
// master = the miss issuer itself, slave = the L1 client plus the L2 lookup path.
interface mpf_svc_vtp_l1_miss_issue_if #(
   parameter int N_TAGS       = 16,
   parameter int VA_PAGE_BITS = 36,
   parameter int PA_PAGE_BITS = 34
);
   localparam int TAG_BITS = $clog2(N_TAGS);

   logic                    miss_valid;
   logic [VA_PAGE_BITS-1:0] miss_pageVA;
   logic                    miss_isSpeculative;
   logic                    miss_ready;

   logic                    lookupRdy;
   logic                    lookupEn;
   logic [VA_PAGE_BITS-1:0] lookupReq_pageVA;
   logic                    lookupReq_isSpeculative;
   logic [TAG_BITS-1:0]     lookupReq_tag;

   logic                    lookupRspValid;
   logic [TAG_BITS-1:0]     lookupRsp_tag;
   logic [PA_PAGE_BITS-1:0] lookupRsp_pagePA;
   logic                    lookupRsp_isBigPage;
   logic                    lookupRsp_mayCache;
   logic                    lookupRsp_error;

   logic                    fill_valid;
   logic [VA_PAGE_BITS-1:0] fill_pageVA;
   logic [PA_PAGE_BITS-1:0] fill_pagePA;
   logic                    fill_isBigPage;
   logic                    fill_mayCache;
   logic                    fill_error;
   logic                    fill_ready;

   modport master (
      input  miss_valid, miss_pageVA, miss_isSpeculative,
      output miss_ready,
      input  lookupRdy,
      output lookupEn, lookupReq_pageVA, lookupReq_isSpeculative, lookupReq_tag,
      input  lookupRspValid, lookupRsp_tag, lookupRsp_pagePA,
      input  lookupRsp_isBigPage, lookupRsp_mayCache, lookupRsp_error,
      output fill_valid, fill_pageVA, fill_pagePA, fill_isBigPage, fill_mayCache, fill_error,
      input  fill_ready
   );

   modport slave (
      output miss_valid, miss_pageVA, miss_isSpeculative,
      input  miss_ready,
      output lookupRdy,
      input  lookupEn, lookupReq_pageVA, lookupReq_isSpeculative, lookupReq_tag,
      output lookupRspValid, lookupRsp_tag, lookupRsp_pagePA,
      output lookupRsp_isBigPage, lookupRsp_mayCache, lookupRsp_error,
      input  fill_valid, fill_pageVA, fill_pagePA, fill_isBigPage, fill_mayCache, fill_error,
      output fill_ready
   );
endinterface

// File: rtl/mpf_svc_vtp_l1_miss_issue.sv
// L1 TLB miss issuer: tags misses, issues L2 lookups 1 cycle after accept, rejoins unordered responses with their VA as L1 fills (>=1 cycle after response).
// Miss intake stalls when lookupRdy is low or all tags are busy; fills hold while fill_ready is low. MPF_VTP_L1_MISS_STATS_EN adds request/high-water stats.
module mpf_svc_vtp_l1_miss_issue #(
   parameter  int N_TAGS       = 16,
   parameter  int VA_PAGE_BITS = 36,
   parameter  int PA_PAGE_BITS = 34,
   localparam int TAG_BITS     = $clog2(N_TAGS)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   mpf_svc_vtp_l1_miss_issue_if.master bus,
   output logic [TAG_BITS:0]          num_outstanding,
   output logic                       err_unexpected_rsp
`ifdef MPF_VTP_L1_MISS_STATS_EN
   ,
   output logic [31:0]                stat_num_reqs,
   output logic [TAG_BITS:0]          stat_max_outstanding
`endif
);
   localparam int CNT_BITS = TAG_BITS + 1;

   logic [N_TAGS-1:0]       busy;
   logic [N_TAGS-1:0]       set_mask;
   logic [N_TAGS-1:0]       clr_mask;
   logic [TAG_BITS-1:0]     alloc_tag;
   logic                    any_free;
   logic                    accept;
   logic                    rsp_ok;
   logic                    rsp_bad;
   logic                    deq;
   logic [CNT_BITS-1:0]     num_nxt;

   // Per-tag VA table, written on allocate and read at fill time.
   logic [VA_PAGE_BITS-1:0] va_tab   [N_TAGS];
   logic                    spec_tab [N_TAGS];

   // Response FIFO; can never overflow since responses are bounded by busy tags.
   logic [TAG_BITS-1:0]     q_tag   [N_TAGS];
   logic [PA_PAGE_BITS-1:0] q_pa    [N_TAGS];
   logic [2:0]              q_flags [N_TAGS];
   logic [TAG_BITS-1:0]     wr_ptr;
   logic [TAG_BITS-1:0]     rd_ptr;
   logic [CNT_BITS-1:0]     q_count;
   logic [TAG_BITS-1:0]     head_tag;

   always_comb begin
      alloc_tag = '0;
      any_free  = 1'b0;
      for (int i = N_TAGS - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            alloc_tag = TAG_BITS'(i);
            any_free  = 1'b1;
         end
      end
   end

   assign bus.miss_ready = reset_n & bus.lookupRdy & any_free;
   assign accept         = bus.miss_valid & bus.miss_ready;
   assign rsp_ok         = bus.lookupRspValid &  busy[bus.lookupRsp_tag];
   assign rsp_bad        = bus.lookupRspValid & ~busy[bus.lookupRsp_tag];

   assign bus.fill_valid = (q_count != '0);
   assign deq            = bus.fill_valid & bus.fill_ready;
   assign head_tag       = q_tag[rd_ptr];

   // Allocation works on the registered bitmap, so a tag freed this cycle cannot be re-picked.
   assign set_mask = accept ? (N_TAGS'(1) << alloc_tag) : '0;
   assign clr_mask = deq    ? (N_TAGS'(1) << head_tag)  : '0;
   assign num_nxt  = num_outstanding + CNT_BITS'(accept) - CNT_BITS'(deq);

   assign bus.fill_pageVA = bus.fill_valid ? va_tab[head_tag] : '0;
   assign bus.fill_pagePA = bus.fill_valid ? q_pa[rd_ptr]     : '0;
   assign {bus.fill_isBigPage, bus.fill_mayCache, bus.fill_error} =
          bus.fill_valid ? q_flags[rd_ptr] : 3'b000;

   always_ff @(posedge clk) begin
      if (accept) begin
         va_tab[alloc_tag]   <= bus.miss_pageVA;
         spec_tab[alloc_tag] <= bus.miss_isSpeculative;
      end
      if (rsp_ok) begin
         q_tag[wr_ptr]   <= bus.lookupRsp_tag;
         q_pa[wr_ptr]    <= bus.lookupRsp_pagePA;
         q_flags[wr_ptr] <= {bus.lookupRsp_isBigPage, bus.lookupRsp_mayCache, bus.lookupRsp_error};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy                        <= '0;
         wr_ptr                      <= '0;
         rd_ptr                      <= '0;
         q_count                     <= '0;
         num_outstanding             <= '0;
         err_unexpected_rsp          <= 1'b0;
         bus.lookupEn                <= 1'b0;
         bus.lookupReq_pageVA        <= '0;
         bus.lookupReq_isSpeculative <= 1'b0;
         bus.lookupReq_tag           <= '0;
      end else begin
         busy               <= (busy | set_mask) & ~clr_mask;
         wr_ptr             <= wr_ptr + TAG_BITS'(rsp_ok);
         rd_ptr             <= rd_ptr + TAG_BITS'(deq);
         q_count            <= q_count + CNT_BITS'(rsp_ok) - CNT_BITS'(deq);
         num_outstanding    <= num_nxt;
         err_unexpected_rsp <= err_unexpected_rsp | rsp_bad;
         bus.lookupEn       <= accept;
         if (accept) begin
            bus.lookupReq_pageVA        <= bus.miss_pageVA;
            bus.lookupReq_isSpeculative <= bus.miss_isSpeculative;
            bus.lookupReq_tag           <= alloc_tag;
         end
      end
   end

`ifdef MPF_VTP_L1_MISS_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_num_reqs        <= '0;
         stat_max_outstanding <= '0;
      end else begin
         stat_num_reqs <= stat_num_reqs + 32'(accept);
         if (num_nxt > stat_max_outstanding) begin
            stat_max_outstanding <= num_nxt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mpf_svc_vtp_l1_miss_issue.sv
// Bench for mpf_svc_vtp_l1_miss_issue: directed scenarios plus random traffic,
// checked by a negedge monitor against a tag-pool / response-queue reference model.
module tb_mpf_svc_vtp_l1_miss_issue;
   localparam int NT  = 16;
   localparam int VAB = 36;
   localparam int PAB = 34;
   localparam int TB  = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mpf_svc_vtp_l1_miss_issue_if #(.N_TAGS(NT), .VA_PAGE_BITS(VAB), .PA_PAGE_BITS(PAB)) bus ();

   logic [TB:0] num_outstanding;
   logic        err_unexpected_rsp;
`ifdef MPF_VTP_L1_MISS_STATS_EN
   logic [31:0] stat_num_reqs;
   logic [TB:0] stat_max_outstanding;
`endif

   mpf_svc_vtp_l1_miss_issue #(.N_TAGS(NT), .VA_PAGE_BITS(VAB), .PA_PAGE_BITS(PAB)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .bus                (bus),
      .num_outstanding    (num_outstanding),
      .err_unexpected_rsp (err_unexpected_rsp)
`ifdef MPF_VTP_L1_MISS_STATS_EN
      ,
      .stat_num_reqs        (stat_num_reqs),
      .stat_max_outstanding (stat_max_outstanding)
`endif
   );

   typedef struct packed {
      logic [TB-1:0]  tag;
      logic [VAB-1:0] va;
      logic           spec;
   } lookup_t;

   typedef struct packed {
      logic [TB-1:0]  tag;
      logic [VAB-1:0] va;
      logic [PAB-1:0] pa;
      logic           big;
      logic           may;
      logic           err;
   } fill_t;

   // Reference model state (owned by the monitor)
   lookup_t        exp_lookup[$];
   fill_t          exp_fill[$];
   bit             m_busy[NT];
   logic [VAB-1:0] m_va[NT];
   logic           m_spec[NT];
   bit             m_err;
   int             m_reqs;
   int             m_max;
   int             n_cmp = 0;
   int             n_fail = 0;
   int             mon_cycles = 0;
   int             rst_seen = 0;

   // Stimulus-owned state
   logic [TB-1:0]  pending[$];
   int             rst_count = 0;
   int             timeouts = 0;
   bit             stim_done = 1'b0;
   logic [127:0]   snap_ctrl;
   logic [127:0]   snap_data;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      int      nbusy;
      bit      do_clear;
      bit      ready_m;
      bit      acc;
      bit      deq;
      bit      had_l;
      logic [TB-1:0] atag;
      logic [TB-1:0] ftag;
      lookup_t l;
      fill_t   f;

      mon_cycles++;
      if (mon_cycles > 50000) begin
         $display("FAIL watchdog: cycles=%0d limit=50000", mon_cycles);
         $fatal(1, "bench did not terminate");
      end

      do_clear = !reset_n;
      if (rst_seen != rst_count) begin
         rst_seen = rst_count;
         check("async_reset_ctrl", snap_ctrl, 128'(0));
         check("async_reset_data", snap_data, 128'(0));
         do_clear = 1'b1;
      end
      if (do_clear) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_err  = 1'b0;
         m_reqs = 0;
         m_max  = 0;
         exp_lookup.delete();
         exp_fill.delete();
      end

      nbusy = 0;
      foreach (m_busy[i]) nbusy += int'(m_busy[i]);

      // Lookup must follow its accept by exactly one cycle
      had_l = (exp_lookup.size() != 0);
      check("lookupEn", 128'(bus.lookupEn), 128'(had_l));
      if (had_l) begin
         l = exp_lookup.pop_front();
         if (bus.lookupEn)
            check("lookup_req", 128'({bus.lookupReq_tag, bus.lookupReq_pageVA, bus.lookupReq_isSpeculative}), 128'(l));
      end

      // Fills in response arrival order
      check("fill_valid", 128'(bus.fill_valid), 128'(exp_fill.size() != 0));
      deq  = 1'b0;
      ftag = '0;
      if (bus.fill_valid && exp_fill.size() != 0) begin
         f = exp_fill[0];
         check("fill_data",
               128'({bus.fill_pageVA, bus.fill_pagePA, bus.fill_isBigPage, bus.fill_mayCache, bus.fill_error}),
               128'({f.va, f.pa, f.big, f.may, f.err}));
         if (bus.fill_ready) begin
            void'(exp_fill.pop_front());
            deq  = 1'b1;
            ftag = f.tag;
         end
      end

      ready_m = reset_n && bus.lookupRdy && (nbusy < NT);
      check("miss_ready", 128'(bus.miss_ready), 128'(ready_m));
      check("num_outstanding", 128'(num_outstanding), 128'(nbusy));
      check("err_unexpected_rsp", 128'(err_unexpected_rsp), 128'(m_err));
`ifdef MPF_VTP_L1_MISS_STATS_EN
      check("stat_num_reqs", 128'(stat_num_reqs), 128'(m_reqs));
      check("stat_max_outstanding", 128'(stat_max_outstanding), 128'(m_max));
`endif

      // Advance the model to the state after the coming posedge
      if (reset_n && bus.lookupRspValid) begin
         if (m_busy[bus.lookupRsp_tag]) begin
            f.tag = bus.lookupRsp_tag;
            f.va  = m_va[bus.lookupRsp_tag];
            f.pa  = bus.lookupRsp_pagePA;
            f.big = bus.lookupRsp_isBigPage;
            f.may = bus.lookupRsp_mayCache;
            f.err = bus.lookupRsp_error;
            exp_fill.push_back(f);
         end else begin
            m_err = 1'b1;
         end
      end
      acc = bus.miss_valid && ready_m;
      if (acc) begin
         atag = '0;
         for (int i = 0; i < NT; i++) begin
            if (!m_busy[i]) begin
               atag = TB'(i);
               break;
            end
         end
         m_busy[atag] = 1'b1;
         m_va[atag]   = bus.miss_pageVA;
         m_spec[atag] = bus.miss_isSpeculative;
         l.tag  = atag;
         l.va   = bus.miss_pageVA;
         l.spec = bus.miss_isSpeculative;
         exp_lookup.push_back(l);
         m_reqs++;
      end
      if (deq) m_busy[ftag] = 1'b0;
      nbusy = 0;
      foreach (m_busy[i]) nbusy += int'(m_busy[i]);
      if (nbusy > m_max) m_max = nbusy;

      if (stim_done) begin
         check("stim_timeouts", 128'(timeouts), 128'(0));
         check("leftover_fills", 128'(exp_fill.size()), 128'(0));
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
         $finish;
      end
   end

   function automatic logic [VAB-1:0] rand_va();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[VAB-1:0];
   endfunction

   function automatic logic [PAB-1:0] rand_pa();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[PAB-1:0];
   endfunction

   // Advance to just after the next posedge; collect issued tags; drop one-cycle pulses
   task automatic cyc();
      @(posedge clk);
      #1;
      if (reset_n && bus.lookupEn) pending.push_back(bus.lookupReq_tag);
      bus.miss_valid     = 1'b0;
      bus.lookupRspValid = 1'b0;
   endtask

   task automatic issue(input logic [VAB-1:0] va, input logic spec);
      bus.miss_valid         = 1'b1;
      bus.miss_pageVA        = va;
      bus.miss_isSpeculative = spec;
   endtask

   task automatic respond_pa(input logic [TB-1:0] t, input logic [PAB-1:0] pa);
      bus.lookupRspValid      = 1'b1;
      bus.lookupRsp_tag       = t;
      bus.lookupRsp_pagePA    = pa;
      bus.lookupRsp_isBigPage = 1'($urandom_range(0, 1));
      bus.lookupRsp_mayCache  = 1'($urandom_range(0, 1));
      bus.lookupRsp_error     = 1'($urandom_range(0, 1));
      for (int i = 0; i < pending.size(); i++) begin
         if (pending[i] == t) begin
            pending.delete(i);
            break;
         end
      end
   endtask

   task automatic respond(input logic [TB-1:0] t);
      respond_pa(t, rand_pa());
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      bus.lookupRdy  = 1'b1;
      bus.fill_ready = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         cyc();
         if (pending.size() == 0 && exp_fill.size() == 0 && exp_lookup.size() == 0)
            done = 1'b1;
         else if (pending.size() != 0)
            respond(pending[0]);
      end
      if (!done) timeouts++;
   endtask

   task automatic reset_pulse();
      bus.miss_valid     = 1'b0;
      bus.lookupRspValid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      snap_ctrl = 128'({bus.lookupEn, bus.fill_valid, bus.miss_ready, err_unexpected_rsp, num_outstanding});
      snap_data = 128'({bus.fill_pageVA, bus.fill_pagePA, bus.fill_isBigPage, bus.fill_mayCache,
                        bus.fill_error, bus.lookupReq_pageVA, bus.lookupReq_tag, bus.lookupReq_isSpeculative});
      rst_count++;
      #1 reset_n = 1'b1;
      pending.delete();
   endtask

   initial begin : stim
      bus.miss_valid          = 1'b0;
      bus.miss_pageVA         = '0;
      bus.miss_isSpeculative  = 1'b0;
      bus.lookupRdy           = 1'b0;
      bus.lookupRspValid      = 1'b0;
      bus.lookupRsp_tag       = '0;
      bus.lookupRsp_pagePA    = '0;
      bus.lookupRsp_isBigPage = 1'b0;
      bus.lookupRsp_mayCache  = 1'b0;
      bus.lookupRsp_error     = 1'b0;
      bus.fill_ready          = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Single miss round trip
      bus.lookupRdy  = 1'b1;
      bus.fill_ready = 1'b1;
      cyc(); issue(36'h12345, 1'b0);
      cyc();
      cyc(); respond_pa(4'd0, 34'h777);
      drain();

      // Fill all tags, then free tag 9 and reallocate it
      bus.fill_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         cyc(); issue(rand_va(), 1'($urandom_range(0, 1)));
      end
      cyc(); respond(4'd9); issue(rand_va(), 1'b1);
      bus.fill_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(); issue(rand_va(), 1'b0);
      end
      drain();

      // Out-of-order responses 3,1,2,0
      for (int i = 0; i < 4; i++) begin
         cyc(); issue(rand_va(), 1'($urandom_range(0, 1)));
      end
      cyc();
      cyc(); respond(4'd3);
      cyc(); respond(4'd1);
      cyc(); respond(4'd2);
      cyc(); respond(4'd0);
      drain();

      // 16 back-to-back responses while the L1 stalls, then release
      bus.fill_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cyc(); issue(rand_va(), 1'($urandom_range(0, 1)));
      end
      cyc();
      cyc();
      for (int i = 0; i < 16; i++) begin
         if (pending.size() != 0) respond(pending[$urandom_range(0, pending.size() - 1)]);
         cyc();
      end
      cyc();
      cyc();
      drain();

      // Random traffic
      for (int c = 0; c < 800; c++) begin
         cyc();
         bus.lookupRdy  = ($urandom_range(0, 3) != 0);
         bus.fill_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 1) != 0) issue(rand_va(), 1'($urandom_range(0, 1)));
         if (pending.size() != 0 && $urandom_range(0, 2) != 0)
            respond(pending[$urandom_range(0, pending.size() - 1)]);
      end
      drain();

      // Response for an idle tag: dropped, sticky error until reset
      cyc(); respond(4'd5);
      repeat (6) cyc();
      reset_pulse();
      repeat (3) cyc();

      // Reset with 8 lookups outstanding; stale response afterwards
      bus.fill_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(); issue(rand_va(), 1'($urandom_range(0, 1)));
      end
      cyc();
      cyc();
      reset_pulse();
      cyc(); issue(rand_va(), 1'b0);
      cyc();
      cyc(); respond(4'd3);
      repeat (4) cyc();
      drain();

      cyc();
      stim_done = 1'b1;
   end

endmodule

// File: doc/mpf_svc_vtp_l1_miss_issue.md
Name: mpf_svc_vtp_l1_miss_issue

Overview:
- Client-side initiator for the L1→L2 VTP lookup stream; feeds the L2 request path, which in turn feeds the dedup filter.
- Accepts L1 TLB misses, allocates a unique request tag, records the miss VA per tag and issues lookups to the L2.
- Buffers the unordered L2 responses, rejoins each with its saved VA and presents fills back to the L1.
- Frees the tag when the fill is accepted.

Parameters:
N_TAGS, 16, number of request tags / max outstanding lookups (power of 2, ≥2)
VA_PAGE_BITS, 36, width of 4KB virtual page index
PA_PAGE_BITS, 34, width of 4KB physical page index
TAG_BITS, $clog2(N_TAGS), width of request tag (derived, do not override)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous assert, active-low
miss_valid  in  1  L1 miss request valid
miss_pageVA  in  VA_PAGE_BITS  missing page VA
miss_isSpeculative  in  1  speculative translation
miss_ready  out  1  miss accepted when miss_valid && miss_ready
lookupRdy  in  1  L2 can accept a request in the following cycle
lookupEn  out  1  L2 request valid (registered)
lookupReq_pageVA  out  VA_PAGE_BITS  request VA
lookupReq_isSpeculative  out  1  request speculative flag
lookupReq_tag  out  TAG_BITS  request tag
lookupRspValid  in  1  L2 response valid, no backpressure
lookupRsp_tag  in  TAG_BITS  response tag
lookupRsp_pagePA  in  PA_PAGE_BITS  translated PA
lookupRsp_isBigPage  in  1  2MB page
lookupRsp_mayCache  in  1  L1 may insert
lookupRsp_error  in  1  translation failed
fill_valid  out  1  fill to L1 valid
fill_pageVA  out  VA_PAGE_BITS  VA saved at issue
fill_pagePA  out  PA_PAGE_BITS  from response
fill_isBigPage / fill_mayCache / fill_error  out  1 each  from response
fill_ready  in  1  L1 accepts fill
num_outstanding  out  TAG_BITS+1  busy tag count
err_unexpected_rsp  out  1  sticky: response for a non-busy tag

Behaviour:
- Reset (reset_n low, async): all tags free; response FIFO empty; lookupEn=0, fill_valid=0, miss_ready=0, num_outstanding=0, err_unexpected_rsp=0; other data outputs 0.
- Tag pool: busy bitmap, one bit per tag. Allocation takes the lowest-index free tag from the registered bitmap.
- miss_ready = lookupRdy && (any tag free). Combinational; may be low while miss_valid is high.
- Accept cycle:
  - Mark the tag busy.
  - Write VA and isSpeculative into the tag-indexed VA table (LUTRAM).
  - Next cycle: lookupEn=1 with the request fields and tag. Latency is exactly 1 cycle; lookupEn is high for one cycle per accept.
- Responses:
  - Every lookupRspValid whose tag is busy is enqueued into a response FIFO (depth N_TAGS, registered output). It cannot overflow because responses ≤ outstanding tags.
  - Response for a non-busy tag: dropped; err_unexpected_rsp set until reset.
- Fill:
  - fill_valid = FIFO not empty. fill_pageVA is read from the VA table at the head's tag.
  - Fills are presented in response arrival order, not request order.
  - Fill outputs are held stable while fill_valid && !fill_ready.
  - On fill_valid && fill_ready: dequeue and clear the tag's busy bit (register update); the tag is allocatable from the next cycle.
  - First fill_valid appears no earlier than 1 cycle after lookupRspValid.
- Simultaneous alloc and free in the same cycle:
  - Both apply.
  - Alloc sees pre-free state, so a tag freed this cycle is never reallocated this cycle.
  - num_outstanding = previous + accept − free.
- Full: with N_TAGS busy, miss_ready=0 regardless of lookupRdy.
- Empty: num_outstanding=0, no fills.
- Tag wrap: a tag index may be reused only after its fill is accepted. The VA table entry is overwritten on realloc.
- Reset mid-operation: all state cleared immediately. Responses arriving after release for pre-reset tags are dropped and set err_unexpected_rsp.

Optional Feature:
MPF_VTP_L1_MISS_STATS_EN
- Defined:
  - Adds output stat_num_reqs (32b): wraps modulo 2^32, +1 per accepted miss.
  - Adds output stat_max_outstanding (TAG_BITS+1): high-water mark of num_outstanding.
  - Both cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single miss VA=0x12345 → lookupEn next cycle, tag 0. Response tag 0, PA=0x777 → fill VA=0x12345 PA=0x777 ≥1 cycle later; num_outstanding returns to 0.
- Issue 16 misses → tags 0..15, miss_ready=0. Fill tag 9 accepted → miss_ready=1 next cycle; next miss gets tag 9.
- Issue tags 0..3, respond in order 3,1,2,0 → four fills in that order, VAs matching original per-tag VAs.
- Hold fill_ready=0 while 16 responses arrive on consecutive cycles → no loss. Release → 16 fills in arrival order, one per cycle.
- Response tag 5 with no outstanding request → no fill; err_unexpected_rsp=1 and stays 1 until reset_n low.
- 8 outstanding, pulse reset_n low mid-cycle → outputs zero asynchronously. After release, a new miss gets tag 0; stale response tag 3 is dropped with err_unexpected_rsp=1.
